// File: rtl/fabric_cfg_pkg.sv
// Shared types and default sizing for the fabric configuration loader.
package fabric_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } cfg_state_t;

   localparam int DEFAULT_CHAIN_LENGTH = 4096;
   localparam int DEFAULT_WORD_WIDTH   = 32;
   localparam int DEFAULT_CLEAR_CYCLES = 2;

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-bit serialiser for the config chain: holding register, valid-bit count,
// and the word_ready / chain_enable handshake decode.
module cfg_serializer
   import fabric_cfg_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter int BITS_W     = 13
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  cfg_state_t            state,
   input  logic [BITS_W-1:0]     bits_left,
   input  logic                  flush,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  chain_in,
   output logic                  chain_enable
);

   localparam int COUNT_W = $clog2(WORD_WIDTH + 1);

   logic [WORD_WIDTH-1:0] holding;
   logic [COUNT_W-1:0]    count;
   logic                  accept;

   // A new word is requested while the last held bit drains, but only if the
   // chain still needs more bits than are already held.
   assign chain_enable = (state == SHIFT) && (count != '0);
   assign word_ready   = (state == SHIFT)
                       && ((count == '0) || ((count == COUNT_W'(1)) && chain_enable))
                       && (int'(bits_left) > int'(count));
   assign accept       = word_valid && word_ready;
   assign chain_in     = holding[0];

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         holding <= '0;
         count   <= '0;
      end else if (flush) begin
         holding <= '0;
         count   <= '0;
      end else if (accept) begin
         holding <= word_data;
         count   <= COUNT_W'(WORD_WIDTH);
      end else if (chain_enable) begin
         holding <= holding >> 1;
         count   <= count - COUNT_W'(1);
      end
   end

endmodule

// File: rtl/config_loader.sv
// Loads a bitstream into the fabric configuration scan chain: clears the chain,
// shifts exactly CHAIN_LENGTH bits, and flags any 1 seen on the chain tail.
module config_loader
   import fabric_cfg_pkg::*;
#(
   parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
   parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
   parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  chain_in,
   output logic                  chain_enable,
   output logic                  chain_nreset,
   input  logic                  chain_out,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int BITS_W = $clog2(CHAIN_LENGTH + 1);
   localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);

   cfg_state_t        state;
   cfg_state_t        next_state;
   logic [CLR_W-1:0]  clear_cnt;
   logic [BITS_W-1:0] bits_left;
   logic              error_flag;
   logic              enter_clear;
   logic              enter_shift;
   logic              last_shift;

   assign enter_clear = start && ((state == IDLE) || (state == DONE));
   assign enter_shift = (state == CLEAR) && (clear_cnt == '0);
   assign last_shift  = chain_enable && (bits_left == BITS_W'(1));
   assign error       = error_flag;

   cfg_serializer #(
      .WORD_WIDTH (WORD_WIDTH),
      .BITS_W     (BITS_W)
   ) u_serializer (
      .clock        (clock),
      .nreset       (nreset),
      .state        (state),
      .bits_left    (bits_left),
      .flush        (last_shift),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .chain_in     (chain_in),
      .chain_enable (chain_enable)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= next_state;
   end

   // Next state plus the state-decoded chain control outputs.
   always_comb begin
      next_state   = state;
      busy         = 1'b0;
      done         = 1'b0;
      chain_nreset = 1'b1;
      case (state)
         IDLE: begin
            if (start) next_state = CLEAR;
         end
         CLEAR: begin
            busy         = 1'b1;
            chain_nreset = 1'b0;
            if (clear_cnt == '0) next_state = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_shift || (bits_left == '0)) next_state = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) next_state = CLEAR;
         end
         default: next_state = IDLE;
      endcase
   end

   // The clear timer counts down to zero so CLEAR lasts exactly CLEAR_CYCLES.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         clear_cnt <= '0;
      end else if (enter_clear) begin
         clear_cnt <= CLR_W'(CLEAR_CYCLES - 1);
      end else if ((state == CLEAR) && (clear_cnt != '0)) begin
         clear_cnt <= clear_cnt - CLR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         bits_left <= '0;
      end else if (enter_shift) begin
         bits_left <= BITS_W'(CHAIN_LENGTH);
      end else if (chain_enable) begin
         bits_left <= bits_left - BITS_W'(1);
      end
   end

   // A cleared chain of the right length only ever returns zeros while shifting.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         error_flag <= 1'b0;
      end else if (enter_clear) begin
         error_flag <= 1'b0;
      end else if (chain_enable && chain_out) begin
         error_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader with a behavioural 20-bit scan chain and a bit scoreboard.
module tb_config_loader;

   localparam int CL     = 20;
   localparam int WW     = 8;
   localparam int CC     = 2;
   localparam int NWORDS = 3;

   logic          clock = 1'b0;
   logic          nreset;
   logic          start;
   logic [WW-1:0] word_data;
   logic          word_valid;
   logic          word_ready;
   logic          chain_in;
   logic          chain_enable;
   logic          chain_nreset;
   logic          chain_out;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct {
      logic [WW-1:0] w0;
      logic [WW-1:0] w1;
      logic [WW-1:0] w2;
      int            gap;
      int            model_len;
      bit            stuck;
      bit            exp_error;
      bit            exp_err_first;
      bit            check_content;
      int            mid_start;
   } vec_t;

   vec_t vecs[7];

   int   checks = 0;
   int   errors = 0;
   bit   sb[$];
   int   pushed;
   int   en_cnt, clr_cycles, acc_cnt, cyc, first_en, last_en;
   logic extra_ready, sample_err_next, err_after_first;
   logic mon_bit;
   bit   abort = 1'b0;
   bit   driver_done;

   logic [CL-1:0] chain_model = '0;
   int            model_len   = CL;
   logic          stuck       = 1'b0;

   always #5 clock = ~clock;

   config_loader #(
      .CHAIN_LENGTH (CL),
      .WORD_WIDTH   (WW),
      .CLEAR_CYCLES (CC)
   ) dut (
      .clock        (clock),
      .nreset       (nreset),
      .start        (start),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .chain_in     (chain_in),
      .chain_enable (chain_enable),
      .chain_nreset (chain_nreset),
      .chain_out    (chain_out),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   // Behavioural chain: head at bit 0, tail at bit model_len-1.
   assign chain_out = stuck ? 1'b1 : chain_model[model_len-1];

   always @(posedge clock) begin
      if (!chain_nreset)     chain_model <= '0;
      else if (chain_enable) chain_model <= {chain_model[CL-2:0], chain_in};
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Observes every cycle: clear length, handshakes, and each shifted bit.
   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (nreset === 1'b1) begin
            if (sample_err_next) begin
               err_after_first = error;
               sample_err_next = 1'b0;
            end
            if (chain_nreset === 1'b0) clr_cycles++;
            if (word_ready === 1'b1 && acc_cnt >= NWORDS) extra_ready = 1'b1;
            if (word_valid === 1'b1 && word_ready === 1'b1) acc_cnt++;
            if (chain_enable === 1'b1) begin
               if (en_cnt == 0) begin
                  first_en        = cyc;
                  sample_err_next = 1'b1;
               end
               last_en = cyc;
               en_cnt++;
               if (sb.size() == 0) begin
                  check_output("sb_underflow", 32'd1, 32'd0);
               end else begin
                  mon_bit = sb.pop_front();
                  check_output("chain_in_bit", {31'd0, chain_in}, {31'd0, mon_bit});
               end
            end
         end
      end
   end

   task automatic reset_monitor();
      en_cnt          = 0;
      clr_cycles      = 0;
      acc_cnt         = 0;
      first_en        = 0;
      last_en         = 0;
      extra_ready     = 1'b0;
      sample_err_next = 1'b0;
      err_after_first = 1'b0;
      pushed          = 0;
      sb.delete();
   endtask

   task automatic pulse_start();
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic send_word(input logic [WW-1:0] w);
      int n;
      int guard;
      n = (CL - pushed < WW) ? (CL - pushed) : WW;
      for (int i = 0; i < n; i++) sb.push_back(w[i]);
      pushed += n;
      word_data  = w;
      word_valid = 1'b1;
      guard = 0;
      @(negedge clock);
      while (!word_ready && !abort && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      if (abort) begin
         word_valid = 1'b0;
         return;
      end
      if (!word_ready) check_output("ready_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1 word_valid = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                 input logic [WW-1:0] w2, input int gap);
      logic [WW-1:0] ws[NWORDS];
      int guard;
      ws = '{w0, w1, w2};
      for (int i = 0; i < NWORDS; i++) begin
         if (i > 0 && gap > 0) begin
            guard = 0;
            @(negedge clock);
            while (!word_ready && !abort && guard < 300) begin
               @(negedge clock);
               guard++;
            end
            repeat (gap) @(posedge clock);
            #1;
         end
         if (abort) break;
         send_word(ws[i]);
         if (abort) break;
      end
      driver_done = 1'b1;
   endtask

   task automatic run_load(input vec_t v);
      logic [WW-1:0] ws[NWORDS];
      logic [CL-1:0] exp_c;
      int guard;
      ws = '{v.w0, v.w1, v.w2};
      for (int k = 0; k < CL; k++) exp_c[CL-1-k] = ws[k/WW][k%WW];
      reset_monitor();
      model_len   = v.model_len;
      stuck       = v.stuck;
      driver_done = 1'b0;
      pulse_start();
      fork
         apply_stimulus(v.w0, v.w1, v.w2, v.gap);
         begin
            @(negedge clock);
            check_output("clear_busy",   {31'd0, busy},         32'd1);
            check_output("clear_nreset", {31'd0, chain_nreset}, 32'd0);
            check_output("clear_error",  {31'd0, error},        32'd0);
            check_output("clear_done",   {31'd0, done},         32'd0);
         end
         begin
            if (v.mid_start > 0) begin
               guard = 0;
               while (en_cnt < v.mid_start && guard < 300) begin
                  @(negedge clock);
                  guard++;
               end
               pulse_start();
            end
         end
      join
      guard = 0;
      @(negedge clock);
      while (done !== 1'b1 && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      check_output("done_reached",    {31'd0, done},            32'd1);
      check_output("error_at_done",   {31'd0, error},           {31'd0, v.exp_error});
      check_output("err_after_first", {31'd0, err_after_first}, {31'd0, v.exp_err_first});
      check_output("enable_count",    en_cnt,                   CL);
      check_output("enable_span",     last_en - first_en + 1,   CL + v.gap * (NWORDS - 1));
      check_output("clear_cycles",    clr_cycles,               CC);
      check_output("sb_empty",        sb.size(),                32'd0);
      check_output("no_extra_ready",  {31'd0, extra_ready},     32'd0);
      check_output("busy_at_done",    {31'd0, busy},            32'd0);
      check_output("enable_at_done",  {31'd0, chain_enable},    32'd0);
      if (v.check_content) check_output("chain_content", {12'd0, chain_model}, {12'd0, exp_c});
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 0, 20, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[1] = '{8'hA5, 8'h3C, 8'h0F, 3, 20, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 0, 18, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[3] = '{8'hA5, 8'h3C, 8'h0F, 0, 20, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[4] = '{8'hA5, 8'h3C, 8'h0F, 0, 20, 1'b1, 1'b1, 1'b1, 1'b0, 0};
      vecs[5] = '{8'h5A, 8'hC3, 8'hF0, 0, 20, 1'b0, 1'b0, 1'b0, 1'b1, 5};
      vecs[6] = '{8'h12, 8'h34, 8'h56, 2, 20, 1'b0, 1'b0, 1'b0, 1'b1, 0};

      nreset     = 1'b0;
      start      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      reset_monitor();
      #12;
      check_output("rst_word_ready",   {31'd0, word_ready},   32'd0);
      check_output("rst_chain_in",     {31'd0, chain_in},     32'd0);
      check_output("rst_chain_enable", {31'd0, chain_enable}, 32'd0);
      check_output("rst_chain_nreset", {31'd0, chain_nreset}, 32'd1);
      check_output("rst_busy",         {31'd0, busy},         32'd0);
      check_output("rst_done",         {31'd0, done},         32'd0);
      check_output("rst_error",        {31'd0, error},        32'd0);
      @(negedge clock);
      nreset = 1'b1;
      repeat (2) @(negedge clock);
      check_output("idle_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 7; i++) run_load(vecs[i]);

      // Reset in the middle of a load, after nine shifts.
      stuck = 1'b0;
      reset_monitor();
      driver_done = 1'b0;
      pulse_start();
      fork
         apply_stimulus(8'hA5, 8'h3C, 8'h0F, 0);
      join_none
      guard = 0;
      while (en_cnt < 9 && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      check_output("mid_nine_shifts", {31'd0, en_cnt >= 9}, 32'd1);
      #1 nreset = 1'b0;
      #1;
      check_output("arst_word_ready",   {31'd0, word_ready},   32'd0);
      check_output("arst_chain_enable", {31'd0, chain_enable}, 32'd0);
      check_output("arst_chain_nreset", {31'd0, chain_nreset}, 32'd1);
      check_output("arst_chain_in",     {31'd0, chain_in},     32'd0);
      check_output("arst_busy",         {31'd0, busy},         32'd0);
      check_output("arst_done",         {31'd0, done},         32'd0);
      check_output("arst_error",        {31'd0, error},        32'd0);
      abort = 1'b1;
      guard = 0;
      while (!driver_done && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      check_output("driver_stopped", {31'd0, driver_done}, 32'd1);
      @(negedge clock);
      nreset = 1'b1;
      abort  = 1'b0;
      repeat (3) @(negedge clock);
      check_output("post_rst_busy",   {31'd0, busy},         32'd0);
      check_output("post_rst_done",   {31'd0, done},         32'd0);
      check_output("post_rst_nreset", {31'd0, chain_nreset}, 32'd1);
      check_output("post_rst_ready",  {31'd0, word_ready},   32'd0);

      run_load(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
